// File: rtl/sklansky_sub_pipe.sv
// sklansky_sub_pipe: pipelined WIDTH-bit subtractor d = a - b (a + ~b + 1) on a
// Sklansky parallel-prefix carry tree split across two register stages.
// Latency: 2 clk edges from the accepting edge to out_valid; throughput 1/cycle.
// Backpressure: valid/ready on both sides; in_ready = !s1_valid | s1 advancing,
//   results held stable while out_valid & !out_ready; nothing dropped or duplicated.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/a/b (operand side),
//   out_valid/out_ready/d/borrow/ovf (result side).
// Optional: define SKLANSKY_SUB_ADD_MODE_EN to add port op (0 = subtract, 1 = add);
//   op travels with its operands, and borrow then reports the carry-out.
module sklansky_sub_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SKLANSKY_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf
);

  localparam int L  = $clog2(WIDTH);   // prefix levels
  localparam int L1 = (L + 1) / 2;     // levels resolved before the s1 register

  // Group generate after prefix levels lo..hi-1. At level k every bit i with
  // bit k set absorbs the group ending just below its 2^k-aligned block; that
  // source index has bit k clear, so in-place update within a level is safe.
  function automatic logic [WIDTH-1:0] pfx_g(input logic [WIDTH-1:0] gi,
                                             input logic [WIDTH-1:0] pi,
                                             input int lo, input int hi);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int src;
    g = gi;
    p = pi;
    for (int k = 0; k < L; k++) begin
      if (k >= lo && k < hi) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> k) & 1) == 1) begin
            src  = ((i >> k) << k) - 1;
            g[i] = g[i] | (p[i] & g[src]);
            p[i] = p[i] & p[src];
          end
        end
      end
    end
    return g;
  endfunction

  // Group propagate after the same levels (independent of generate).
  function automatic logic [WIDTH-1:0] pfx_p(input logic [WIDTH-1:0] pi,
                                             input int lo, input int hi);
    logic [WIDTH-1:0] p;
    int src;
    p = pi;
    for (int k = 0; k < L; k++) begin
      if (k >= lo && k < hi) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> k) & 1) == 1) begin
            src  = ((i >> k) << k) - 1;
            p[i] = p[i] & p[src];
          end
        end
      end
    end
    return p;
  endfunction

  // Handshake
  logic s1_valid, s2_valid, s2_load, s1_adv, accept;

  assign s2_load   = !s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_load;
  assign in_ready  = !s1_valid | s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1 combinational: operand conditioning and first prefix levels
  logic             in_add, in_cin;
  logic [WIDTH-1:0] bx, pv, gv;

`ifdef SKLANSKY_SUB_ADD_MODE_EN
  assign in_add = op;
`else
  assign in_add = 1'b0;
`endif
  assign in_cin = ~in_add;

  always_comb begin
    bx    = in_add ? b : ~b;
    pv    = a ^ bx;
    gv    = a & bx;
    // carry-in folded into bit 0 so the tree needs no separate cin input
    gv[0] = gv[0] | (pv[0] & in_cin);
  end

  logic [WIDTH-1:0] s1_p, s1_g, s1_pp;
  logic             s1_amsb, s1_bmsb, s1_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_pp    <= '0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
      s1_add   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_p     <= pv;
        s1_g     <= pfx_g(gv, pv, 0, L1);
        s1_pp    <= pfx_p(pv, 0, L1);
        s1_amsb  <= a[WIDTH-1];
        s1_bmsb  <= b[WIDTH-1];
        s1_add   <= in_add;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 combinational: remaining levels, sum and flags
  logic [WIDTH-1:0] c2, d_n;
  logic             bor_n, ovf_n, sgn_diff;

  always_comb begin
    c2       = pfx_g(s1_g, s1_pp, L1, L);
    d_n      = s1_p ^ {c2[WIDTH-2:0], ~s1_add};
    bor_n    = s1_add ? c2[WIDTH-1] : ~c2[WIDTH-1];
    // subtract overflows only for differing operand signs, add only for equal
    sgn_diff = s1_amsb ^ s1_bmsb;
    ovf_n    = (s1_add ? ~sgn_diff : sgn_diff) & (d_n[WIDTH-1] ^ s1_amsb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      d        <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      // an empty slot leaves the last result on d/borrow/ovf
      if (s1_valid) begin
        d      <= d_n;
        borrow <= bor_n;
        ovf    <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// tb_sklansky_sub_pipe: scoreboard bench for sklansky_sub_pipe (WIDTH = 6).
// The driver pushes the expected {d,borrow,ovf} on each accepted pair; a monitor
// pops and compares on every consumed result and checks hold-stability in stalls.
module tb_sklansky_sub_pipe;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, op, out_valid, out_ready, borrow, ovf;
  logic [W-1:0] a, b, d;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int or_mode  = 1;           // 0: out_ready low, 1: high, 2: random
  logic [W+1:0] sb_q[$];      // expected {d, borrow, ovf}

  always #5 clk = ~clk;

  sklansky_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SKLANSKY_SUB_ADD_MODE_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference for the exhaustive stream
  function automatic logic [W+1:0] ref_res(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic opv);
    logic [W:0]   s;
    logic [W-1:0] dv;
    logic         c, o;
    if (opv) begin
      s  = {1'b0, av} + {1'b0, bv};
      dv = s[W-1:0];
      c  = s[W];
      o  = (av[W-1] == bv[W-1]) && (dv[W-1] != av[W-1]);
    end else begin
      s  = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
      dv = s[W-1:0];
      c  = ~s[W];
      o  = (av[W-1] != bv[W-1]) && (dv[W-1] != av[W-1]);
    end
    return {dv, c, o};
  endfunction

  // out_ready owner
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  logic         stall_prev = 1'b0;
  logic [W+2:0] prev_v;
  logic [W+1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("hold_stable", {out_valid, d, borrow, ovf}, prev_v);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_output", sb_q.size(), 1);
        end else begin
          exp_v = sb_q.pop_front();
          chk("result", {d, borrow, ovf}, exp_v);
          pop_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_v     = {out_valid, d, borrow, ovf};
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv,
                      input logic [W+1:0] exp);
    int n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    op = opv;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        break;
      end
      n++;
      if (n > 300) begin
        chk("accept_timeout", {31'b0, in_ready}, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", sb_q.size(), 0);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
    #1;
    chk("reset_outputs", {out_valid, d, borrow, ovf}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency and first result
    or_mode = 1;
    send(6'b001010, 6'b000011, 1'b0, {6'b000111, 1'b0, 1'b0});
    chk("lat_after_accept_edge", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    chk("lat_second_edge", {31'b0, out_valid}, 1);

    // Directed vectors, back-to-back
    send(6'b000011, 6'b001010, 1'b0, {6'b111001, 1'b1, 1'b0});
    send(6'b100000, 6'b000001, 1'b0, {6'b011111, 1'b0, 1'b1});
    send(6'b000000, 6'b000001, 1'b0, {6'b111111, 1'b1, 1'b0});
    send(6'b011111, 6'b111111, 1'b0, {6'b100000, 1'b1, 1'b1});
    send(6'b000000, 6'b000000, 1'b0, {6'b000000, 1'b0, 1'b0});
    drain();

    // Backpressure: two accepted, third held off until out_ready rises
    or_mode = 0;
    send(6'b000101, 6'b000010, 1'b0, {6'b000011, 1'b0, 1'b0});
    send(6'b000010, 6'b000101, 1'b0, {6'b111101, 1'b1, 1'b0});
    fork
      send(6'b111111, 6'b111111, 1'b0, {6'b000000, 1'b0, 1'b0});
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", {31'b0, in_ready}, 0);
          chk("full_out_valid", {31'b0, out_valid}, 1);
          chk("stall_d", {26'b0, d}, 6'b000011);
        end
        @(posedge clk); #1;
        or_mode = 1;
      end
    join
    drain();

    // Exhaustive stream with random gaps and random out_ready
    or_mode = 2;
    base = pop_cnt;
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(W'(ai), W'(bi), 1'b0, ref_res(W'(ai), W'(bi), 1'b0));
      end
    end
    or_mode = 1;
    drain();
    chk("exhaustive_count", pop_cnt - base, 4096);

    // Reset with both stages full
    or_mode = 0;
    send(6'b000111, 6'b000001, 1'b0, {6'b000110, 1'b0, 1'b0});
    send(6'b000001, 6'b000111, 1'b0, {6'b111010, 1'b1, 1'b0});
    chk("pre_reset_out_valid", {31'b0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {out_valid, d, borrow, ovf}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    or_mode = 1;
    send(6'b010100, 6'b000101, 1'b0, {6'b001111, 1'b0, 1'b0});
    chk("post_reset_no_stale", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    chk("post_reset_out_valid", {31'b0, out_valid}, 1);
    drain();

`ifdef SKLANSKY_SUB_ADD_MODE_EN
    // Add mode, interleaved with subtract at full rate
    send(6'b111111, 6'b000001, 1'b1, {6'b000000, 1'b1, 1'b0});
    send(6'b001010, 6'b000011, 1'b0, {6'b000111, 1'b0, 1'b0});
    send(6'b001010, 6'b000011, 1'b1, {6'b001101, 1'b0, 1'b0});
    send(6'b011111, 6'b000001, 1'b1, {6'b100000, 1'b0, 1'b1});
    send(6'b100000, 6'b000001, 1'b0, {6'b011111, 1'b0, 1'b1});
    drain();
`endif

    chk("queue_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
